// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: synchronizes MEI/MSI/MTI lines, reports them
// as mip bits and schedules one prioritized, held request into the trap path.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       external_interrupt,
  input  logic       software_interrupt,
  input  logic       timer_interrupt,
  input  logic       csr_rd_mstatus_mie,
  input  logic       csr_rd_mie_meie,
  input  logic       csr_rd_mie_msie,
  input  logic       csr_rd_mie_mtie,
  input  logic       irq_ack,
  output logic       csr_set_mip_meip,
  output logic       csr_set_mip_msip,
  output logic       csr_set_mip_mtip,
  output logic       irq_req,
  output logic [3:0] irq_code,
  output logic       irq_busy
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;

  logic [SYNC_STAGES-1:0] ext_sync_p0;
  logic [SYNC_STAGES-1:0] sw_sync_p0;
  logic [SYNC_STAGES-1:0] tmr_sync_p0;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic       q_mei;
  logic       q_msi;
  logic       q_mti;
  logic       any_q;
  logic       latched_q;
  logic [3:0] sel_code;

  // Synchronizer chains; the last flop of each chain is the mip level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync_p0 <= '0;
      sw_sync_p0  <= '0;
      tmr_sync_p0 <= '0;
    end else begin
      ext_sync_p0 <= {ext_sync_p0[SYNC_STAGES-2:0], external_interrupt};
      sw_sync_p0  <= {sw_sync_p0[SYNC_STAGES-2:0], software_interrupt};
      tmr_sync_p0 <= {tmr_sync_p0[SYNC_STAGES-2:0], timer_interrupt};
    end
  end

  assign csr_set_mip_meip = ext_sync_p0[SYNC_STAGES-1];
  assign csr_set_mip_msip = sw_sync_p0[SYNC_STAGES-1];
  assign csr_set_mip_mtip = tmr_sync_p0[SYNC_STAGES-1];

  assign q_mei = csr_rd_mstatus_mie & csr_rd_mie_meie & csr_set_mip_meip;
  assign q_msi = csr_rd_mstatus_mie & csr_rd_mie_msie & csr_set_mip_msip;
  assign q_mti = csr_rd_mstatus_mie & csr_rd_mie_mtie & csr_set_mip_mtip;
  assign any_q = q_mei | q_msi | q_mti;

  always_comb begin
    sel_code = 4'd0;
    if (q_mei)      sel_code = CODE_MEI;
    else if (q_msi) sel_code = CODE_MSI;
    else if (q_mti) sel_code = CODE_MTI;
  end

  always_comb begin
    latched_q = 1'b0;
    case (irq_code)
      CODE_MEI: latched_q = q_mei;
      CODE_MSI: latched_q = q_msi;
      CODE_MTI: latched_q = q_mti;
      default:  latched_q = 1'b0;
    endcase
  end

  // Scheduler: code is latched on entry to REQ and held until the state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      irq_code <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_q) begin
            state    <= ST_REQ;
            irq_code <= sel_code;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state <= ST_HOLDOFF;
            cnt   <= CNT_W'(HOLDOFF - 1);
          end else if (!latched_q) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          // Expiry takes IDLE's scheduling decision in the same cycle, so the
          // next request can appear HOLDOFF+1 cycles after acceptance.
          if (cnt == '0) begin
            if (any_q) begin
              state    <= ST_REQ;
              irq_code <= sel_code;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_req  = (state == ST_REQ);
  assign irq_busy = (state == ST_HOLDOFF);

endmodule
